// File: rtl/uart_psram_bridge_pkg.sv
// rtl/uart_psram_bridge_pkg.sv - shared state encoding and opcodes for the UART-to-PSRAM bridge
package uart_psram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ISSUE,
    WAIT1,
    WAIT_BUSY,
    RESP
  } bridge_state_t;

  localparam logic [7:0] OP_READ  = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;

  function automatic logic is_cmd_op(input logic [7:0] b);
    return (b == OP_READ) || (b == OP_WRITE);
  endfunction

endpackage

// File: rtl/uart_psram_bridge_if.sv
// rtl/uart_psram_bridge_if.sv - UART byte streams, PSRAM access port and status of the bridge
interface uart_psram_bridge_if #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 2
);

  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic                    rx_read;
  logic                    tx_busy;
  logic                    tx_write;
  logic [7:0]              tx_data;
  logic                    psram_stb;
  logic                    psram_we;
  logic [8*ADDR_BYTES-1:0] psram_addr;
  logic [8*DATA_BYTES-1:0] psram_wdat;
  logic                    psram_busy;
  logic [8*DATA_BYTES-1:0] psram_rdat;
  logic [7:0]              err_cnt;
  logic                    active;

  modport slave (
    input  rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    output rx_read, tx_write, tx_data, psram_stb, psram_we,
           psram_addr, psram_wdat, err_cnt, active
  );

  modport master (
    output rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    input  rx_read, tx_write, tx_data, psram_stb, psram_we,
           psram_addr, psram_wdat, err_cnt, active
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - emits a left-justified word MSB byte first, never pulsing on back-to-back cycles
module uart_tx_serializer #(
  parameter int NBYTES = 2,
  localparam int WW = 8 * NBYTES,
  localparam int CW = $clog2(NBYTES + 1)
) (
  input  logic          clk_out,
  input  logic          arst_n,
  input  logic          load,
  input  logic [WW-1:0] load_word,
  input  logic [CW-1:0] load_cnt,
  input  logic          tx_busy,
  output logic          tx_write,
  output logic [7:0]    tx_data,
  output logic          last
);

  logic [WW-1:0] word_q;
  logic [CW-1:0] rem_q;
  logic          wr_q;

  // wr_q blocks a second pulse on the cycle right after a send, before the UART has raised busy
  assign tx_write = (rem_q != '0) && !tx_busy && !wr_q;
  assign tx_data  = word_q[WW-1 -: 8];
  assign last     = tx_write && (rem_q == CW'(1));

  always_ff @(posedge clk_out or negedge arst_n) begin
    if (!arst_n) begin
      word_q <= '0;
      rem_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= tx_write;
      if (load) begin
        word_q <= load_word;
        rem_q  <= load_cnt;
      end else if (tx_write) begin
        word_q <= word_q << 8;
        rem_q  <= rem_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_psram_bridge.sv
// rtl/uart_psram_bridge.sv - decodes UART command bytes into one PSRAM access and replies over the UART
module uart_psram_bridge
  import uart_psram_bridge_pkg::*;
#(
  parameter int         ADDR_BYTES  = 3,
  parameter int         DATA_BYTES  = 2,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] ACK_BYTE    = 8'hA5,
  parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
  input logic                clk_out,
  input logic                arst_n,
  uart_psram_bridge_if.slave bus
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(DATA_BYTES + 1);

  bridge_state_t state, state_n;

  logic [7:0]    opcode_q;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdat_q;
  logic [7:0]    err_q;

  logic          latch_op, shift_addr, shift_data, byte_last, timeout, err_inc;
  logic          ser_load, ser_last;
  logic [DW-1:0] ser_word, err_word, ack_word;
  logic [CW-1:0] ser_cnt;
  logic          in_get;

  assign in_get = (state == GET_ADDR) || (state == GET_DATA);

  always_comb begin
    err_word = '0;
    err_word[DW-1 -: 8] = ERR_BYTE;
    ack_word = '0;
    ack_word[DW-1 -: 8] = ACK_BYTE;
  end

  always_ff @(posedge clk_out or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    latch_op   = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    byte_last  = 1'b0;
    timeout    = 1'b0;
    err_inc    = 1'b0;
    ser_load   = 1'b0;
    ser_word   = '0;
    ser_cnt    = '0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (is_cmd_op(bus.rx_data)) begin
            latch_op = 1'b1;
            state_n  = GET_ADDR;
          end else begin
            err_inc  = 1'b1;
            ser_load = 1'b1;
            ser_word = err_word;
            ser_cnt  = CW'(1);
            state_n  = RESP;
          end
        end
      end
      GET_ADDR, GET_DATA: begin
        if (bus.rx_valid) begin
          if (state == GET_ADDR) begin
            shift_addr = 1'b1;
            byte_last  = (byte_cnt == 3'(ADDR_BYTES - 1));
            if (byte_last) state_n = (opcode_q == OP_WRITE) ? GET_DATA : ISSUE;
          end else begin
            shift_data = 1'b1;
            byte_last  = (byte_cnt == 3'(DATA_BYTES - 1));
            if (byte_last) state_n = ISSUE;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          // the partial command is simply abandoned; the next opcode clears addr/wdat
          timeout  = 1'b1;
          err_inc  = 1'b1;
          ser_load = 1'b1;
          ser_word = err_word;
          ser_cnt  = CW'(1);
          state_n  = RESP;
        end
      end
      ISSUE: state_n = WAIT1;
      WAIT1: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.psram_busy) begin
          ser_load = 1'b1;
          if (opcode_q == OP_WRITE) begin
            ser_word = ack_word;
            ser_cnt  = CW'(1);
          end else begin
            ser_word = bus.psram_rdat;
            ser_cnt  = CW'(DATA_BYTES);
          end
          state_n = RESP;
        end
      end
      RESP: if (ser_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.rx_valid && (state inside {ISSUE, WAIT1, WAIT_BUSY, RESP})) err_inc = 1'b1;
  end

  always_ff @(posedge clk_out or negedge arst_n) begin
    if (!arst_n) begin
      opcode_q <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      err_q    <= '0;
    end else begin
      if (latch_op) begin
        opcode_q <= bus.rx_data;
        byte_cnt <= '0;
        addr_q   <= '0;
        wdat_q   <= '0;
      end else if (shift_addr || shift_data) begin
        byte_cnt <= byte_last ? 3'd0 : byte_cnt + 3'd1;
      end
      if (shift_addr) addr_q <= (addr_q << 8) | AW'(bus.rx_data);
      if (shift_data) wdat_q <= (wdat_q << 8) | DW'(bus.rx_data);

      if (in_get && !bus.rx_valid && !timeout) to_cnt <= to_cnt + TW'(1);
      else                                     to_cnt <= '0;

      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  uart_tx_serializer #(.NBYTES(DATA_BYTES)) u_ser (
    .clk_out  (clk_out),
    .arst_n   (arst_n),
    .load     (ser_load),
    .load_word(ser_word),
    .load_cnt (ser_cnt),
    .tx_busy  (bus.tx_busy),
    .tx_write (bus.tx_write),
    .tx_data  (bus.tx_data),
    .last     (ser_last)
  );

  assign bus.rx_read    = bus.rx_valid;
  assign bus.psram_stb  = (state == ISSUE);
  assign bus.psram_we   = (state == ISSUE) && (opcode_q == OP_WRITE);
  assign bus.psram_addr = addr_q;
  assign bus.psram_wdat = wdat_q;
  assign bus.err_cnt    = err_q;
  assign bus.active     = (state != IDLE);

endmodule

// File: tb/tb_uart_psram_bridge.sv
// tb/tb_uart_psram_bridge.sv - scoreboard bench for uart_psram_bridge in two parameter sets
module tb_uart_psram_bridge;

  localparam logic [7:0] ERR = 8'hEE;
  localparam logic [7:0] ACK = 8'hA5;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        chk_w;
  } stb_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        sel = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] rdat_m = 32'h0;
  int          tx_bcnt = 0;
  int          pb_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_err = 0;
  logic        prev_txw = 1'b0;

  logic [7:0]  exp_tx[$];
  stb_t        exp_stb[$];

  always #5 clk = ~clk;

  uart_psram_bridge_if #(.ADDR_BYTES(3), .DATA_BYTES(2)) if_a ();
  uart_psram_bridge_if #(.ADDR_BYTES(1), .DATA_BYTES(4)) if_b ();

  uart_psram_bridge #(.ADDR_BYTES(3), .DATA_BYTES(2), .TIMEOUT_CYC(50)) dut_a (
    .clk_out(clk), .arst_n(arst_n), .bus(if_a)
  );
  uart_psram_bridge #(.ADDR_BYTES(1), .DATA_BYTES(4), .TIMEOUT_CYC(50)) dut_b (
    .clk_out(clk), .arst_n(arst_n), .bus(if_b)
  );

  assign if_a.rx_valid   = rx_valid & ~sel;
  assign if_b.rx_valid   = rx_valid & sel;
  assign if_a.rx_data    = rx_data;
  assign if_b.rx_data    = rx_data;
  assign if_a.tx_busy    = (tx_bcnt != 0);
  assign if_b.tx_busy    = (tx_bcnt != 0);
  assign if_a.psram_busy = (pb_cnt != 0);
  assign if_b.psram_busy = (pb_cnt != 0);
  assign if_a.psram_rdat = rdat_m[15:0];
  assign if_b.psram_rdat = rdat_m;

  logic        rx_read, tx_write, psram_stb, psram_we, active, psram_busy;
  logic [7:0]  tx_data, err_cnt;
  logic [31:0] psram_addr, psram_wdat;

  assign rx_read    = sel ? if_b.rx_read   : if_a.rx_read;
  assign tx_write   = sel ? if_b.tx_write  : if_a.tx_write;
  assign tx_data    = sel ? if_b.tx_data   : if_a.tx_data;
  assign psram_stb  = sel ? if_b.psram_stb : if_a.psram_stb;
  assign psram_we   = sel ? if_b.psram_we  : if_a.psram_we;
  assign active     = sel ? if_b.active    : if_a.active;
  assign err_cnt    = sel ? if_b.err_cnt   : if_a.err_cnt;
  assign psram_addr = sel ? 32'(if_b.psram_addr) : 32'(if_a.psram_addr);
  assign psram_wdat = sel ? 32'(if_b.psram_wdat) : 32'(if_a.psram_wdat);
  assign psram_busy = (pb_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // UART and PSRAM controller responders: busy follows a send / strobe like real peripherals
  always @(posedge clk) begin
    if (tx_write)         tx_bcnt <= 3;
    else if (tx_bcnt > 0) tx_bcnt <= tx_bcnt - 1;
    if (psram_stb)        pb_cnt <= 5;
    else if (pb_cnt > 0)  pb_cnt <= pb_cnt - 1;
  end

  always @(negedge clk) begin
    if (tx_write) begin
      chk("tx_spacing", 32'(prev_txw), 32'd0);
      if (exp_tx.size() == 0) chk("tx_extra", 32'(exp_tx.size()), 32'd1);
      else                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    prev_txw = tx_write;
    if (psram_stb) begin
      if (exp_stb.size() == 0) chk("stb_extra", 32'(exp_stb.size()), 32'd1);
      else begin
        stb_t e;
        e = exp_stb.pop_front();
        chk("stb_we", 32'(psram_we), 32'(e.we));
        chk("stb_addr", psram_addr, e.addr);
        if (e.chk_w) chk("stb_wdat", psram_wdat, e.wdat);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1 chk("rx_read", 32'(rx_read), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!active && exp_tx.size() == 0 && exp_stb.size() == 0) break;
    end
    chk("idle_active", 32'(active), 32'd0);
    chk("idle_tx_left", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit inject);
    int ab = sel ? 1 : 3;
    int nb = sel ? 4 : 2;
    stb_t e;
    e.we = wr; e.addr = addr; e.wdat = data; e.chk_w = wr;
    exp_stb.push_back(e);
    if (wr) exp_tx.push_back(ACK);
    else begin
      rdat_m = data;
      for (int i = nb - 1; i >= 0; i--) exp_tx.push_back(8'(data >> (8 * i)));
    end
    send_byte(wr ? 8'h01 : 8'h00);
    for (int i = ab - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(8'(addr >> (8 * i)));
    end
    if (wr)
      for (int i = nb - 1; i >= 0; i--) send_byte(8'(data >> (8 * i)));
    if (inject) begin
      for (int i = 0; i < 50 && !psram_busy; i++) @(negedge clk);
      chk("inject_busy", 32'(psram_busy), 32'd1);
      send_byte(8'h55);
      bump_err();
    end
    wait_idle();
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic bad_op(input logic [7:0] b);
    exp_tx.push_back(ERR);
    send_byte(b);
    bump_err();
    wait_idle();
    chk("err_cnt_bad", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_tx_write", 32'(tx_write), 32'd0);
    chk("rst_stb", 32'(psram_stb), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_addr", psram_addr, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    do_cmd(1'b0, 32'h123456, 32'hBEEF, 1'b0);
    do_cmd(1'b1, 32'h000010, 32'hCAFE, 1'b0);
    bad_op(8'h7F);
    do_cmd(1'b0, 32'hABCDEF, 32'h1234, 1'b0);

    exp_tx.push_back(ERR);
    send_byte(8'h00);
    send_byte(8'h12);
    cyc = 0;
    for (int i = 0; i < 200 && !tx_write; i++) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'd50);
    bump_err();
    wait_idle();
    chk("err_cnt_to", 32'(err_cnt), 32'(exp_err));
    do_cmd(1'b0, 32'h00FEDC, 32'h5A5A, 1'b0);

    do_cmd(1'b0, 32'h000001, 32'h1111, 1'b1);

    for (int i = 0; i < 300; i++) bad_op(8'h80 + 8'(i % 64));
    chk("err_sat", 32'(err_cnt), 32'hFF);

    begin
      stb_t e;
      e.we = 1'b0; e.addr = 32'h000042; e.wdat = 32'h0; e.chk_w = 1'b0;
      exp_stb.push_back(e);
      exp_tx.push_back(8'hC0);
      rdat_m = 32'hC0DE;
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h42);
      for (int i = 0; i < 100 && exp_tx.size() != 0; i++) @(negedge clk);
      chk("mid_first_tx", 32'(exp_tx.size()), 32'd0);
      @(posedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("mid_active", 32'(active), 32'd0);
      chk("mid_tx_write", 32'(tx_write), 32'd0);
      chk("mid_tx_data", 32'(tx_data), 32'd0);
      chk("mid_stb", 32'(psram_stb), 32'd0);
      chk("mid_we", 32'(psram_we), 32'd0);
      chk("mid_err", 32'(err_cnt), 32'd0);
      chk("mid_addr", psram_addr, 32'd0);
      chk("mid_wdat", psram_wdat, 32'd0);
      exp_err = 0;
      repeat (5) @(negedge clk);
      arst_n = 1'b1;
      repeat (20) @(negedge clk);
    end

    sel = 1'b1;
    do_cmd(1'b0, 32'h7E, 32'hDEADBEEF, 1'b0);
    do_cmd(1'b1, 32'h05, 32'h01020304, 1'b0);
    do_cmd(1'b0, 32'hFF, 32'h80A0C0E1, 1'b0);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
